// File: rtl/status_array_if.sv
// status_array_if: request/response bundle for status_array.
// master drives requests, slave returns ready and read responses.
interface status_array_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int ROW_WIDTH  = 16,
    parameter int NUM_BLOCKS = 4
);
    logic                  i_halt;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [ROW_WIDTH-1:0]  i_data;
    logic                  i_wen;
    logic [NUM_BLOCKS-1:0] i_wmask;
    logic                  i_valid;
    logic                  o_ready;
    logic [ROW_WIDTH-1:0]  o_rdata;
    logic                  o_rvalid;
    logic                  o_rerr;
    logic                  o_all_written;
    logic                  o_parity_err;

    modport master (
        output i_halt, i_addr, i_data, i_wen, i_wmask, i_valid,
        input  o_ready, o_rdata, o_rvalid, o_rerr, o_all_written,
        input  o_parity_err
    );

    modport slave (
        input  i_halt, i_addr, i_data, i_wen, i_wmask, i_valid,
        output o_ready, o_rdata, o_rvalid, o_rerr, o_all_written,
        output o_parity_err
    );
endinterface

// File: rtl/status_array.sv
// status_array: masked-write row array that tracks which rows were fully written.
// Define STATUS_ARRAY_PARITY_EN for per-block even parity on stored rows.
module status_array #(
    parameter int ADDR_WIDTH = 6,
    parameter int ROW_WIDTH  = 16,
    parameter int NUM_BLOCKS = 4
) (
    input logic           clk,
    input logic           rst,
    status_array_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BW    = ROW_WIDTH / NUM_BLOCKS;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {
        TRACKING,
        COMPLETE
    } state_t;

    logic [ROW_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     written;
    logic [ADDR_WIDTH:0]  cnt;
    state_t               state;
    logic                 all_written;
    logic [ROW_WIDTH-1:0] rdata;
    logic                 rvalid;
    logic                 rerr;
    logic                 accept;
    logic                 wr;
    logic                 rd;
    logic                 full;
    logic                 row_ok;

    assign accept = bus.i_valid & ~bus.i_halt & ~rst;
    assign wr     = accept & bus.i_wen;
    assign rd     = accept & ~bus.i_wen;
    assign full   = &bus.i_wmask;
    assign row_ok = written[bus.i_addr];

    // Row storage carries no reset; only the written bits qualify it.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                if (bus.i_wmask[k]) begin
                    mem[bus.i_addr][k*BW +: BW] <= bus.i_data[k*BW +: BW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= TRACKING;
            cnt         <= '0;
            written     <= '0;
            all_written <= 1'b0;
        end else if (wr && full && !row_ok) begin
            written[bus.i_addr] <= 1'b1;
            cnt                 <= cnt + 1'b1;
            unique case (state)
                TRACKING: begin
                    if (cnt == LAST) begin
                        state       <= COMPLETE;
                        all_written <= 1'b1;
                    end
                end
                COMPLETE: all_written <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rerr   <= 1'b0;
            rdata  <= '0;
        end else if (!bus.i_halt) begin
            rvalid <= rd;
            rerr   <= rd & ~row_ok;
            if (rd) begin
                rdata <= row_ok ? mem[bus.i_addr] : '0;
            end
        end
    end

`ifdef STATUS_ARRAY_PARITY_EN
    logic [NUM_BLOCKS-1:0] par_q [DEPTH];
    logic                  rd_mis;
    logic                  perr;

    always_ff @(posedge clk) begin
        if (wr) begin
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                if (bus.i_wmask[k]) begin
                    par_q[bus.i_addr][k] <= ^bus.i_data[k*BW +: BW];
                end
            end
        end
    end

    always_comb begin
        rd_mis = 1'b0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if ((^mem[bus.i_addr][k*BW +: BW]) != par_q[bus.i_addr][k]) begin
                rd_mis = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr <= 1'b0;
        end else if (!bus.i_halt) begin
            perr <= rd & row_ok & rd_mis;
        end
    end

    assign bus.o_parity_err = perr;
`else
    assign bus.o_parity_err = 1'b0;
`endif

    assign bus.o_ready       = ~rst & ~bus.i_halt;
    assign bus.o_rdata       = rdata;
    assign bus.o_rvalid      = rvalid;
    assign bus.o_rerr        = rerr;
    assign bus.o_all_written = all_written;
endmodule

// File: tb/tb_status_array.sv
// tb_status_array: randomized and directed bench for status_array.
// Reference model tracks row contents and full-write set with plain arrays.
module tb_status_array;
    logic clk;
    logic rst;
    int   nerr;
    int   nchk;

    status_array_if #(.ADDR_WIDTH(6), .ROW_WIDTH(16), .NUM_BLOCKS(4)) bus ();

    status_array #(.ADDR_WIDTH(6), .ROW_WIDTH(16), .NUM_BLOCKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] m_mem [64];
    bit          m_wr  [64];
    logic [15:0] e_rdata;
    bit          e_rvalid;
    bit          e_rerr;
    bit          e_all;
    bit          e_perr;

    function automatic bit all_rows();
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(m_wr[i]);
        return n == 64;
    endfunction

    task automatic step(bit v, bit w, int a, logic [15:0] d,
                        logic [3:0] m, bit h);
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = v;
        bus.i_wen   = w;
        bus.i_addr  = 6'(a);
        bus.i_data  = d;
        bus.i_wmask = m;
        bus.i_halt  = h;
        @(posedge clk);
        if (!h) begin
            e_perr = 1'b0;
            if (!v) begin
                e_rvalid = 1'b0;
                e_rerr   = 1'b0;
            end else if (w) begin
                for (int k = 0; k < 4; k++)
                    if (m[k]) m_mem[a][k*4 +: 4] = d[k*4 +: 4];
                if (m == 4'hF) m_wr[a] = 1'b1;
                e_rvalid = 1'b0;
                e_rerr   = 1'b0;
            end else begin
                e_rvalid = 1'b1;
                e_rerr   = !m_wr[a];
                e_rdata  = m_wr[a] ? m_mem[a] : 16'h0;
            end
            e_all = all_rows();
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = 1'($urandom);
        bus.i_halt  = 1'($urandom);
        bus.i_wen   = 1'($urandom);
        bus.i_wmask = 4'hF;
        @(posedge clk);
        for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
        e_rdata  = 16'h0;
        e_rvalid = 1'b0;
        e_rerr   = 1'b0;
        e_all    = 1'b0;
        e_perr   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nchk++;
        if (bus.o_ready !== 1'b0) begin
            nerr++; $display("FAIL rst_ready got=%0b exp=0", bus.o_ready);
        end
        nchk++;
        if ({bus.o_rvalid, bus.o_rerr, bus.o_all_written, bus.o_parity_err}
            !== 4'b0) begin
            nerr++;
            $display("FAIL rst_flags got=%b%b%b%b exp=0000", bus.o_rvalid,
                     bus.o_rerr, bus.o_all_written, bus.o_parity_err);
        end
        nchk++;
        if (bus.o_rdata !== 16'h0) begin
            nerr++; $display("FAIL rst_rdata got=%h exp=0000", bus.o_rdata);
        end
        step(0, 0, 0, 0, 0, 0);
        nchk++;
        if (bus.o_ready !== 1'b1) begin
            nerr++; $display("FAIL post_rst_ready got=%0b exp=1", bus.o_ready);
        end
    endtask

    task automatic test_uninit();
        do_reset();
        step(1, 0, 9, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_rerr, bus.o_rdata} !== {2'b11, 16'h0}) begin
            nerr++;
            $display("FAIL uninit_read got=%b%b/%h exp=11/0000",
                     bus.o_rvalid, bus.o_rerr, bus.o_rdata);
        end
        step(1, 1, 9, 16'hABCD, 4'b0111, 0);
        step(1, 0, 9, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_rerr, bus.o_rdata} !== {2'b11, 16'h0}) begin
            nerr++;
            $display("FAIL partial_read got=%b%b/%h exp=11/0000",
                     bus.o_rvalid, bus.o_rerr, bus.o_rdata);
        end
        step(0, 0, 9, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_rerr} !== 2'b00) begin
            nerr++;
            $display("FAIL idle_clear got=%b%b exp=00", bus.o_rvalid, bus.o_rerr);
        end
    endtask

    task automatic test_masked();
        step(1, 1, 5, 16'hFFFF, 4'hF, 0);
        step(1, 1, 5, 16'h0000, 4'b0101, 0);
        nchk++;
        if (bus.o_rvalid !== 1'b0) begin
            nerr++; $display("FAIL wr_rvalid got=%0b exp=0", bus.o_rvalid);
        end
        step(1, 0, 5, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_rerr, bus.o_rdata} !== {2'b10, 16'hF0F0}) begin
            nerr++;
            $display("FAIL masked_read got=%b%b/%h exp=10/f0f0",
                     bus.o_rvalid, bus.o_rerr, bus.o_rdata);
        end
        step(1, 1, 5, 16'h1234, 4'h0, 0);
        step(1, 0, 5, 0, 0, 0);
        nchk++;
        if (bus.o_rdata !== 16'hF0F0) begin
            nerr++; $display("FAIL noop_write got=%h exp=f0f0", bus.o_rdata);
        end
    endtask

    task automatic test_halt();
        step(1, 1, 5, 16'h5A5A, 4'hF, 0);
        step(1, 0, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, (i != 1), 5, 16'(i + 16'h0100), 4'hF, 1);
            nchk++;
            if (bus.o_ready !== 1'b0) begin
                nerr++; $display("FAIL halt_ready got=%0b exp=0", bus.o_ready);
            end
            nchk++;
            if ({bus.o_rvalid, bus.o_rerr, bus.o_rdata} !== {2'b10, 16'h5A5A})
            begin
                nerr++;
                $display("FAIL halt_hold got=%b%b/%h exp=10/5a5a",
                         bus.o_rvalid, bus.o_rerr, bus.o_rdata);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0, 0);
        nchk++;
        if (bus.o_rdata !== 16'h5A5A) begin
            nerr++; $display("FAIL halt_nowrite got=%h exp=5a5a", bus.o_rdata);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        for (int r = 0; r < 64; r++) begin
            step(1, 1, r, 16'h0, 4'hF, 0);
            if (r >= 5 && r < 62) step(1, 1, 5, 16'h0, 4'hF, 0);
            nchk++;
            if (bus.o_all_written !== (r == 63)) begin
                nerr++;
                $display("FAIL sweep_all row=%0d got=%0b exp=%0b", r,
                         bus.o_all_written, (r == 63));
            end
        end
        step(1, 0, 10, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_rerr, bus.o_rdata} !== {2'b10, 16'h0}) begin
            nerr++;
            $display("FAIL sweep_read got=%b%b/%h exp=10/0000",
                     bus.o_rvalid, bus.o_rerr, bus.o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d40;
        do_reset();
        for (int r = 0; r < 30; r++) step(1, 1, r, 16'($urandom), 4'hF, 0);
        do_reset();
        nchk++;
        if (bus.o_all_written !== 1'b0) begin
            nerr++; $display("FAIL mid_rst_all got=%0b exp=0", bus.o_all_written);
        end
        d40 = 16'h0;
        for (int r = 0; r < 63; r++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (r == 40) d40 = d;
            step(1, 1, r, d, 4'hF, 0);
        end
        nchk++;
        if (bus.o_all_written !== 1'b0) begin
            nerr++; $display("FAIL mid_63_all got=%0b exp=0", bus.o_all_written);
        end
        step(1, 0, 40, 0, 0, 0);
        nchk++;
        if ({bus.o_rerr, bus.o_rdata} !== {1'b0, d40}) begin
            nerr++;
            $display("FAIL mid_read40 got=%b/%h exp=0/%h", bus.o_rerr,
                     bus.o_rdata, d40);
        end
        step(1, 0, 63, 0, 0, 0);
        nchk++;
        if (bus.o_rerr !== 1'b1) begin
            nerr++; $display("FAIL mid_read63 rerr got=%0b exp=1", bus.o_rerr);
        end
        step(1, 1, 63, 16'h7777, 4'hF, 0);
        nchk++;
        if (bus.o_all_written !== 1'b1) begin
            nerr++; $display("FAIL mid_64_all got=%0b exp=1", bus.o_all_written);
        end
        step(1, 1, 7, 16'h1, 4'h1, 1);
        step(1, 0, 2, 0, 0, 0);
        nchk++;
        if (bus.o_all_written !== 1'b1) begin
            nerr++; $display("FAIL all_sticky got=%0b exp=1", bus.o_all_written);
        end
    endtask

    task automatic test_random();
        bit v;
        bit w;
        bit h;
        logic [3:0] m;
        logic [22:0] got;
        logic [22:0] exp;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) != 0);
            w = 1'($urandom);
            h = ($urandom_range(0, 7) == 0);
            m = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            step(v, w, $urandom_range(0, 63), 16'($urandom), m, h);
            got = {bus.o_ready, bus.o_rvalid, bus.o_rerr, bus.o_all_written,
                   bus.o_parity_err, 2'b00, bus.o_rdata};
            exp = {!h, e_rvalid, e_rerr, e_all, e_perr, 2'b00, e_rdata};
            nchk++;
            if (got !== exp) begin
                nerr++;
                $display("FAIL random_cycle i=%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_parity();
        step(1, 1, 3, 16'h1357, 4'hF, 0);
`ifdef STATUS_ARRAY_PARITY_EN
        dut.par_q[3][0] = ~dut.par_q[3][0];
        step(1, 0, 3, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_parity_err} !== 2'b11) begin
            nerr++;
            $display("FAIL parity_inject got=%b%b exp=11", bus.o_rvalid,
                     bus.o_parity_err);
        end
`else
        step(1, 0, 3, 0, 0, 0);
        nchk++;
        if ({bus.o_rvalid, bus.o_parity_err} !== 2'b10) begin
            nerr++;
            $display("FAIL parity_off got=%b%b exp=10", bus.o_rvalid,
                     bus.o_parity_err);
        end
`endif
        step(0, 0, 0, 0, 0, 0);
        nchk++;
        if (bus.o_parity_err !== 1'b0) begin
            nerr++; $display("FAIL parity_idle got=%0b exp=0", bus.o_parity_err);
        end
    endtask

    initial begin
        nerr        = 0;
        nchk        = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_halt  = 1'b0;
        bus.i_wen   = 1'b0;
        bus.i_addr  = '0;
        bus.i_data  = '0;
        bus.i_wmask = '0;
        e_rdata     = 16'h0;
        e_rvalid    = 1'b0;
        e_rerr      = 1'b0;
        e_all       = 1'b0;
        e_perr      = 1'b0;
        for (int i = 0; i < 64; i++) m_wr[i] = 1'b0;
        test_reset();
        test_uninit();
        test_masked();
        test_halt();
        test_sweep();
        test_reset_mid();
        test_random();
        test_parity();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
